contador_universal: RTL

Parametrised, programmable N-bit counter. It adds the following to the basic free-running counter:
- enable, up/down direction and synchronous load
- programmable modulo limit and a clock-enable prescaler
- three terminal-count modes: wrap, saturate and one-shot
- a terminal-count pulse and a sticky overflow flag

Used as the general timer/event-counter primitive in lab designs (display refresh, debounce timing, event tallies).

---
 rtl/contador_pkg.sv | 16 +
 rtl/contador_prescaler.sv | 37 +++
 rtl/contador_universal.sv | 99 +++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared types for the universal counter: terminal-count modes and the
// run/halt control states.
package contador_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/contador_prescaler.sv
// Clock-enable prescaler: emits a one-cycle tick every presc_div+1 enabled
// cycles. The phase is held while en is low and restarted by clr.
module contador_prescaler #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [PW-1:0] presc_div,
  input  logic          clr,
  output logic          tick
);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  always_comb begin
    tick    = en && (presc_q == presc_div);
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/contador_universal.sv
// Programmable up/down counter with modulo limit, prescaler and
// wrap/saturate/one-shot terminal behaviour; all outputs are registered.
module contador_universal #(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          up_dn,
  input  logic [1:0]    mode,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  input  logic [N-1:0]  max_val,
  input  logic [PW-1:0] presc_div,
  input  logic          clear_ovf,
  output logic [N-1:0]  count,
  output logic          tc,
  output logic          ovf,
  output logic          done
);

  import contador_pkg::*;

  logic [N-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  state_t       state_q, state_d;
  logic         tick;
  logic         isTerminal;
  mode_t        modeSel;

  // A load restarts the prescaler phase so the loaded value gets a full period.
  contador_prescaler #(.PW(PW)) u_presc (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .presc_div (presc_div),
    .clr       (load),
    .tick      (tick)
  );

  always_comb begin
    case (mode)
      2'b01:   modeSel = MODE_SAT;
      2'b10:   modeSel = MODE_ONESHOT;
      default: modeSel = MODE_WRAP;
    endcase
  end

  assign isTerminal = up_dn ? (count_q >= max_val) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    state_d = state_q;
    if (clear_ovf) begin
      ovf_d = 1'b0;
    end
    if (load) begin
      count_d = (load_val > max_val) ? max_val : load_val;
      state_d = RUN;
    end else if (tick && (state_q == RUN)) begin
      if (!isTerminal) begin
        count_d = up_dn ? (count_q + 1'b1) : (count_q - 1'b1);
      end else begin
        // A terminal set overrides a simultaneous clear_ovf.
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        case (modeSel)
          MODE_SAT:     count_d = up_dn ? max_val : '0;
          MODE_ONESHOT: state_d = HALT;
          default:      count_d = up_dn ? '0 : max_val;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= RUN;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign done  = (state_q == HALT);

endmodule
